// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sound_pkg
// Description : Shared types for the sound effect sequencer: effect ids
//               (numerically equal to their priority), FSM states, and the
//               note ROM that turns (effect, note index) into a note.
// Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

   // Effect id doubles as its priority: a larger value wins and may preempt.
   typedef enum logic [1:0] {
      EFF_WALL   = 2'd0,
      EFF_PADDLE = 2'd1,
      EFF_BRICK  = 2'd2,
      EFF_LOST   = 2'd3
   } effect_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [15:0] half_period;
      logic [7:0]  dur;
      logic        last;
   } note_t;

   // Unused slots return a silent one-unit last note so a corrupted index
   // still terminates the effect.
   function automatic note_t note_rom(input effect_e eff, input logic [1:0] idx);
      logic [3:0] key;
      key      = {eff, idx};
      note_rom = '{half_period: 16'd0, dur: 8'd1, last: 1'b1};
      case (key)
         4'b00_00: note_rom = '{half_period: 16'd2271, dur: 8'd20,  last: 1'b1};
         4'b01_00: note_rom = '{half_period: 16'd1135, dur: 8'd40,  last: 1'b1};
         4'b10_00: note_rom = '{half_period: 16'd851,  dur: 8'd40,  last: 1'b0};
         4'b10_01: note_rom = '{half_period: 16'd637,  dur: 8'd40,  last: 1'b1};
         4'b11_00: note_rom = '{half_period: 16'd1135, dur: 8'd100, last: 1'b0};
         4'b11_01: note_rom = '{half_period: 16'd1515, dur: 8'd100, last: 1'b0};
         4'b11_10: note_rom = '{half_period: 16'd2271, dur: 8'd200, last: 1'b1};
         default:  ;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_divider.sv
`default_nettype none
// ============================================================================
// Module      : pulse_divider
// Description : Free-running modulo-DIV counter; pulse_o is high during the
//               cycle the count sits at DIV-1. clear_i forces the count back
//               to zero on the next edge.
// Revision    : 1.0 - initial release
// Ports       : clk_i   - clock
//               rst_i   - asynchronous active-high reset
//               clear_i - synchronous restart of the count
//               pulse_o - one-cycle strobe every DIV cycles
// ============================================================================
module pulse_divider #(
   parameter int DIV = 50
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic pulse_o
);

   localparam int             c_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

   logic [c_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || (cnt_q == c_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pulse_o = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sound_effect_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sound_effect_sequencer
// Description : Turns one-cycle game-event pulses into short note sequences
//               for the square-wave synth and generates the shared audio
//               tick. One effect plays at a time; higher or equal priority
//               events preempt, lower ones are dropped.
// Revision    : 1.0 - initial release
// Ports       : clk_i            - system clock
//               rst_i            - asynchronous active-high reset
//               wall_hit_i       - event pulse, priority 0
//               paddle_hit_i     - event pulse, priority 1
//               brick_hit_i      - event pulse, priority 2
//               ball_lost_i      - event pulse, priority 3
//               mute_i           - level, silences output and blocks events
//               advance_tick_o   - strobe every TICK_DIV cycles
//               enable_o         - synth enable
//               half_period_o    - synth half period in ticks
//               busy_o           - effect in progress
// ============================================================================
module sound_effect_sequencer
   import sound_pkg::*;
#(
   parameter int TICK_DIV = 50,
   parameter int MS_DIV   = 50000,
   parameter int GAP_MS   = 10
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wall_hit_i,
   input  logic        paddle_hit_i,
   input  logic        brick_hit_i,
   input  logic        ball_lost_i,
   input  logic        mute_i,
   output logic        advance_tick_o,
   output logic        enable_o,
   output logic [15:0] half_period_o,
   output logic        busy_o
);

   localparam logic [7:0] c_GAP_UNITS = 8'(GAP_MS);

   state_e      state_q, state_d;
   effect_e     effect_q, effect_d;
   logic [1:0]  note_q, note_d;
   logic [7:0]  unit_q, unit_d;
   logic        enable_q, enable_d;
   logic [15:0] hp_q, hp_d;
   logic        busy_q, busy_d;
   logic        tick_q;

   logic        w_tick_pulse;
   logic        w_ms_pulse;
   logic        w_ms_clear;
   logic        w_trig_any;
   effect_e     w_trig_eff;
   note_t       w_note;
   logic        w_unit_done;
   logic        w_last_end;
   logic        w_accept;

   pulse_divider #(.DIV(TICK_DIV)) u_tick_div (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (1'b0),
      .pulse_o (w_tick_pulse)
   );

   // The ms prescaler only runs while timing a note or a gap, so every
   // PLAY/GAP interval starts from a zero count.
   assign w_ms_clear = (state_q != ST_PLAY) && (state_q != ST_GAP);

   pulse_divider #(.DIV(MS_DIV)) u_ms_div (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (w_ms_clear),
      .pulse_o (w_ms_pulse)
   );

   always_comb begin
      w_trig_any  = wall_hit_i | paddle_hit_i | brick_hit_i | ball_lost_i;
      w_trig_eff  = ball_lost_i  ? EFF_LOST   :
                    brick_hit_i  ? EFF_BRICK  :
                    paddle_hit_i ? EFF_PADDLE : EFF_WALL;
      w_note      = note_rom(effect_q, note_q);
      // Interval ends on the ms strobe that completes the last unit.
      w_unit_done = w_ms_pulse &&
                    ((state_q == ST_PLAY) ? (unit_q == (w_note.dur - 8'd1))
                                          : (unit_q == (c_GAP_UNITS - 8'd1)));
      w_last_end  = (state_q == ST_PLAY) && w_unit_done && w_note.last;
      // Any event may start a new effect on the final cycle of the last note.
      w_accept    = !mute_i && w_trig_any &&
                    ((state_q == ST_IDLE) || (w_trig_eff >= effect_q) || w_last_end);

      state_d  = state_q;
      effect_d = effect_q;
      note_d   = note_q;
      unit_d   = unit_q;
      hp_d     = hp_q;

      if (w_ms_pulse) begin
         unit_d = unit_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: ;
         ST_LOAD: begin
            hp_d    = w_note.half_period;
            unit_d  = '0;
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (w_unit_done) begin
               unit_d  = '0;
               state_d = w_note.last ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (w_unit_done) begin
               unit_d  = '0;
               note_d  = note_q + 2'd1;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (w_accept) begin
         state_d  = ST_LOAD;
         effect_d = w_trig_eff;
         note_d   = '0;
         unit_d   = '0;
      end

      if (mute_i) begin
         state_d = ST_IDLE;
         unit_d  = '0;
      end

      // Outputs are registered alongside the state they describe.
      enable_d = (state_d == ST_PLAY);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         effect_q <= EFF_WALL;
         note_q   <= '0;
         unit_q   <= '0;
         enable_q <= 1'b0;
         hp_q     <= '0;
         busy_q   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         effect_q <= effect_d;
         note_q   <= note_d;
         unit_q   <= unit_d;
         enable_q <= enable_d;
         hp_q     <= hp_d;
         busy_q   <= busy_d;
         tick_q   <= w_tick_pulse;
      end
   end

   assign advance_tick_o = tick_q;
   assign enable_o       = enable_q;
   assign half_period_o  = hp_q;
   assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_effect_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_effect_sequencer
// Description : Self-checking bench. A timeline model (effect start offset ->
//               LOAD / PLAY / GAP position) predicts every output each cycle;
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_effect_sequencer;

   localparam int TICK_DIV = 4;
   localparam int MS_DIV   = 10;
   localparam int GAP_MS   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wall = 1'b0, paddle = 1'b0, brick = 1'b0, lost = 1'b0, mute = 1'b0;
   logic        tick, en, busy;
   logic [15:0] hp;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   sound_effect_sequencer #(
      .TICK_DIV (TICK_DIV),
      .MS_DIV   (MS_DIV),
      .GAP_MS   (GAP_MS)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wall_hit_i     (wall),
      .paddle_hit_i   (paddle),
      .brick_hit_i    (brick),
      .ball_lost_i    (lost),
      .mute_i         (mute),
      .advance_tick_o (tick),
      .enable_o       (en),
      .half_period_o  (hp),
      .busy_o         (busy)
   );

   // ---------------- note tables ----------------
   function automatic int n_notes(input int e);
      case (e)
         0, 1:    return 1;
         2:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int note_hp(input int e, input int i);
      case (e * 4 + i)
         0:  return 2271;
         4:  return 1135;
         8:  return 851;
         9:  return 637;
         12: return 1135;
         13: return 1515;
         14: return 2271;
         default: return 0;
      endcase
   endfunction

   function automatic int note_dur(input int e, input int i);
      case (e * 4 + i)
         0:  return 20;
         4, 8, 9: return 40;
         12, 13:  return 100;
         14: return 200;
         default: return 0;
      endcase
   endfunction

   // Cycles from LOAD of the first note to the end of the last note.
   function automatic int eff_len(input int e);
      int total = 0;
      for (int i = 0; i < n_notes(e); i++) begin
         total += 1 + note_dur(e, i) * MS_DIV;
         if (i < n_notes(e) - 1) total += GAP_MS * MS_DIV;
      end
      return total;
   endfunction

   // Half period if offset falls inside a playing note, else -1.
   function automatic int play_hp(input int e, input int off);
      int o = 0;
      for (int i = 0; i < n_notes(e); i++) begin
         if (off > o && off <= o + note_dur(e, i) * MS_DIV) return note_hp(e, i);
         o += 1 + note_dur(e, i) * MS_DIV + GAP_MS * MS_DIV;
      end
      return -1;
   endfunction

   // ---------------- behavioural model ----------------
   int m_n = 0;
   bit m_act = 1'b0;
   int m_eff = 0;
   int m_off = 0;
   int m_hp  = 0;
   bit m_en  = 1'b0;

   always @(posedge clk) begin
      int p, h;
      if (rst) begin
         m_n = 0; m_act = 1'b0; m_eff = 0; m_off = 0; m_hp = 0; m_en = 1'b0;
      end else begin
         m_n++;
         p = lost ? 3 : brick ? 2 : paddle ? 1 : wall ? 0 : -1;
         if (mute) begin
            m_act = 1'b0;
         end else if (p >= 0 && (!m_act || p >= m_eff || m_off == eff_len(m_eff) - 1)) begin
            m_act = 1'b1; m_eff = p; m_off = 0;
         end else if (m_act) begin
            m_off++;
            if (m_off >= eff_len(m_eff)) m_act = 1'b0;
         end
         h    = m_act ? play_hp(m_eff, m_off) : -1;
         m_en = (h >= 0);
         if (h >= 0) m_hp = h;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   logic [15:0] prev_hp = 16'd0;
   logic        prev_en = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("tick", 32'(tick), 32'((m_n != 0) && (m_n % TICK_DIV == 0)));
         chk("enable", 32'(en), 32'(m_en));
         chk("busy", 32'(busy), 32'(m_act));
         chk("half_period", 32'(hp), 32'(m_hp));
         if (!rst && hp !== prev_hp) chk("hp_change_while_enabled", 32'(prev_en), 32'd0);
         prev_hp = hp;
         prev_en = en;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_post(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at a negedge; holds the event bits for exactly one posedge.
   task automatic fire(input logic [3:0] m);
      {lost, brick, paddle, wall} = m;
      @(negedge clk);
      {lost, brick, paddle, wall} = 4'b0000;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_enable", 32'(en), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_hp", 32'(hp), 32'd0);
      chk("reset_tick", 32'(tick), 32'd0);
      rst = 1'b0;

      // Tick cadence after release.
      wait_post(3); chk("tick_cycle3", 32'(tick), 32'd0);
      wait_post(1); chk("tick_cycle4", 32'(tick), 32'd1);
      wait_post(4); chk("tick_cycle8", 32'(tick), 32'd1);
      chk("idle_enable", 32'(en), 32'd0);

      // Single-note PADDLE effect.
      @(negedge clk); fire(4'b0010);
      wait_post(1);   chk("paddle_en_t2", 32'(en), 32'd1);
                      chk("paddle_hp_t2", 32'(hp), 32'd1135);
      wait_post(399); chk("paddle_en_last", 32'(en), 32'd1);
      wait_post(1);   chk("paddle_en_off", 32'(en), 32'd0);
                      chk("paddle_busy_off", 32'(busy), 32'd0);

      // Three-note BALL_LOST effect with gaps.
      @(negedge clk); fire(4'b1000);
      wait_post(1);    chk("lost_n0_hp", 32'(hp), 32'd1135);
      wait_post(1000); chk("lost_gap_en", 32'(en), 32'd0);
                       chk("lost_gap_busy", 32'(busy), 32'd1);
      wait_post(21);   chk("lost_n1_hp", 32'(hp), 32'd1515);
      wait_post(1021); chk("lost_n2_hp", 32'(hp), 32'd2271);
                       chk("lost_n2_en", 32'(en), 32'd1);
      wait_post(2000); chk("lost_done_busy", 32'(busy), 32'd0);

      // BRICK playing: lower WALL ignored, BALL_LOST preempts.
      @(negedge clk); fire(4'b0100);
      wait_post(50);
      @(negedge clk); fire(4'b0001);
      wait_post(1);   chk("brick_keeps_hp", 32'(hp), 32'd851);
                      chk("brick_keeps_en", 32'(en), 32'd1);
      @(negedge clk); fire(4'b1000);
      chk("preempt_en_low", 32'(en), 32'd0);
      chk("preempt_hp_held", 32'(hp), 32'd851);
      wait_post(1);   chk("preempt_hp_new", 32'(hp), 32'd1135);
                      chk("preempt_en_high", 32'(en), 32'd1);

      // MUTE aborts and blocks events.
      wait_post(20);
      @(negedge clk); mute = 1'b1;
      wait_post(1);   chk("mute_en", 32'(en), 32'd0);
                      chk("mute_busy", 32'(busy), 32'd0);
      @(negedge clk); fire(4'b0010);
      wait_post(2);   chk("mute_blocks", 32'(busy), 32'd0);
      @(negedge clk); mute = 1'b0;

      // Simultaneous WALL+BRICK -> BRICK; WALL on the last cycle restarts.
      @(negedge clk); fire(4'b0101);
      wait_post(1);   chk("simul_hp0", 32'(hp), 32'd851);
      wait_post(421); chk("simul_hp1", 32'(hp), 32'd637);
      @(negedge clk);
      repeat (399) @(negedge clk);
      fire(4'b0001);
      chk("lastend_load_busy", 32'(busy), 32'd1);
      chk("lastend_load_en", 32'(en), 32'd0);
      wait_post(1);   chk("lastend_hp", 32'(hp), 32'd2271);
                      chk("lastend_en", 32'(en), 32'd1);

      // Asynchronous reset mid-note.
      wait_post(50);
      @(negedge clk); #1 rst = 1'b1;
      #1;
      chk("async_rst_en", 32'(en), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_hp", 32'(hp), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_post(30);  chk("post_rst_en", 32'(en), 32'd0);
                      chk("post_rst_busy", 32'(busy), 32'd0);

      wait_post(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
